// File: rtl/bigreg_collector.sv
// Builds a wide register out of 16-bit mem-map writes, offers it downstream, then clears the fresh bits.
// Optional macro BIGREG_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module bigreg_collector #(
    parameter int unsigned BASE_ID  = 32,
    parameter int unsigned SAMPLES  = 2,
    parameter int unsigned ID_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ID_WIDTH-1:0]     wr_id,
    input  logic [15:0]             wr_data,
    output logic [SAMPLES*16-1:0]   reg_out,
    output logic                    reg_valid,
    input  logic                    reg_ready,
    output logic                    clr_en,
    output logic [ID_WIDTH-1:0]     clr_id,
    output logic                    busy,
    output logic                    err_pulse
`ifdef BIGREG_ERR_COUNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int unsigned CNT_W = $clog2(SAMPLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_CLEAR   = 2'd2;

    localparam logic [ID_WIDTH-1:0] BASE_L    = ID_WIDTH'(BASE_ID);
    localparam logic [ID_WIDTH-1:0] OFF_VALID = ID_WIDTH'(SAMPLES);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SAMPLES);

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_clr_idx;
    logic [SAMPLES-1:0]      r_fresh;
    logic [SAMPLES*16-1:0]   r_reg_out;
    logic                    r_reg_valid;
    logic                    r_clr_en;
    logic [ID_WIDTH-1:0]     r_clr_id;
    logic                    r_busy;
    logic                    r_err_pulse;

    logic [1:0]              w_next_state;
    logic [CNT_W-1:0]        w_next_idx;
    logic [ID_WIDTH-1:0]     w_off;
    logic                    w_rel;
    logic                    w_commit;
    logic                    w_err;
    logic                    w_word_we;
    logic                    w_fresh_clr;

    // Offset of the write relative to word 0; relevant range is 0..SAMPLES inclusive.
    assign w_off    = wr_id - BASE_L;
    assign w_rel    = wr_en && (wr_id >= BASE_L) && (w_off <= OFF_VALID);
    assign w_commit = (w_off == OFF_VALID);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = '0;
        w_err        = 1'b0;
        w_word_we    = 1'b0;
        w_fresh_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rel) begin
                    if (!w_commit) begin
                        w_word_we = 1'b1;
                    end else if (!wr_data[0]) begin
                        w_fresh_clr  = 1'b1;
                        w_next_state = S_CLEAR;
                    end else if (&r_fresh) begin
                        w_next_state = S_PRESENT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                w_err = w_rel;
                if (reg_ready) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_err       = w_rel;
                w_fresh_clr = 1'b1;
                if (r_clr_idx == CNT_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_idx = r_clr_idx + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output and datapath registers, all derived from the next-state decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_out   <= '0;
            r_fresh     <= '0;
            r_reg_valid <= 1'b0;
            r_clr_en    <= 1'b0;
            r_clr_id    <= '0;
            r_busy      <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_reg_valid <= (w_next_state == S_PRESENT);
            r_busy      <= (w_next_state != S_IDLE);
            r_clr_en    <= (w_next_state == S_CLEAR);
            r_clr_id    <= (w_next_state == S_CLEAR) ? (BASE_L + ID_WIDTH'(w_next_idx)) : '0;
            r_err_pulse <= w_err;
            if (w_fresh_clr) begin
                r_fresh <= '0;
            end else if (w_word_we) begin
                for (int unsigned k = 0; k < SAMPLES; k++) begin
                    if (w_off == ID_WIDTH'(k)) begin
                        r_reg_out[16*k +: 16] <= wr_data;
                        r_fresh[k]            <= 1'b1;
                    end
                end
            end
        end
    end

    assign reg_out   = r_reg_out;
    assign reg_valid = r_reg_valid;
    assign clr_en    = r_clr_en;
    assign clr_id    = r_clr_id;
    assign busy      = r_busy;
    assign err_pulse = r_err_pulse;

`ifdef BIGREG_ERR_COUNT_EN
    logic [7:0] r_err_count;

    // Saturating count of rejected or dropped writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
